// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: widths, station tag map and the CDB bundle.
package tomasulo_pkg;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 3;

    // Tag 0 means "no producer" in Qj/Qk and the register status table.
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(0);

    // Station tag assignments.
    localparam logic [TAG_W-1:0] TAG_ADD0  = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_ADD1  = TAG_W'(2);
    localparam logic [TAG_W-1:0] TAG_ADD2  = TAG_W'(3);
    localparam logic [TAG_W-1:0] TAG_MUL0  = TAG_W'(4);
    localparam logic [TAG_W-1:0] TAG_MUL1  = TAG_W'(5);
    localparam logic [TAG_W-1:0] TAG_LOAD0 = TAG_W'(6);
    localparam logic [TAG_W-1:0] TAG_LOAD1 = TAG_W'(7);

    // Requester index on the CDB arbiter.
    localparam int unsigned UNIT_ADD  = 0;
    localparam int unsigned UNIT_MUL  = 1;
    localparam int unsigned UNIT_LOAD = 2;

    // Broadcast bundle snooped by reservation stations and the register status table.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned j;

    // Scan from ptr upward modulo N; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[IW'(j)]) begin
                any            = 1'b1;
                idx            = IW'(j);
                grant[IW'(j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units,
// registered one-cycle broadcast, sticky requester protocol checker.
module cdb_arbiter
    import tomasulo_pkg::*;
(
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*TAG_W-1:0]  req_tag,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   cdb_hold,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [DATA_W-1:0]      cdb_data,
    output logic                   proto_err
);

    cdb_t                   cdb_q;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NREQ-1:0]        pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   xfer_c;
    logic [TAG_W-1:0]       sel_tag;
    logic [DATA_W-1:0]      sel_data;
    logic [IDX_W-1:0]       ptr_next;
    logic [NREQ-1:0]        pend_q;
    logic [NREQ*TAG_W-1:0]  tag_q;
    logic [NREQ*DATA_W-1:0] data_q;
    logic                   err_c;
    logic                   err_q;

    rr_pick #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant is suppressed by hold and while reset is asserted.
    assign req_ready = (Resetn && !cdb_hold) ? pick_grant : '0;
    assign xfer_c    = pick_any && !cdb_hold;

    // Mux the winning unit's payload and compute the pointer after it.
    always_comb begin
        sel_tag  = req_tag[32'(pick_idx)*TAG_W +: TAG_W];
        sel_data = req_data[32'(pick_idx)*DATA_W +: DATA_W];
        ptr_next = (pick_idx == IDX_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
    end

    // A request left pending last edge must still be valid with the same payload;
    // a valid request must never carry the "no producer" tag.
    always_comb begin
        err_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pend_q[i] &&
                (!req_valid[i] ||
                 req_tag[i*TAG_W +: TAG_W]   != tag_q[i*TAG_W +: TAG_W] ||
                 req_data[i*DATA_W +: DATA_W] != data_q[i*DATA_W +: DATA_W])) begin
                err_c = 1'b1;
            end
            if (req_valid[i] && req_tag[i*TAG_W +: TAG_W] == TAG_NONE) begin
                err_c = 1'b1;
            end
        end
    end

    // Broadcast register and round-robin pointer; valid lasts one cycle per transfer.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cdb_q  <= '0;
            rr_ptr <= '0;
        end else if (xfer_c) begin
            cdb_q.valid <= 1'b1;
            cdb_q.tag   <= sel_tag;
            cdb_q.data  <= sel_data;
            rr_ptr      <= ptr_next;
        end else begin
            cdb_q.valid <= 1'b0;
        end
    end

    // Snapshot of still-waiting requests and their payload, plus sticky error.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pend_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= req_valid & ~req_ready;
            tag_q  <= req_tag;
            data_q <= req_data;
            err_q  <= err_q | err_c;
        end
    end

    assign cdb_valid = cdb_q.valid;
    assign cdb_tag   = cdb_q.tag;
    assign cdb_data  = cdb_q.data;
    assign proto_err = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    logic                   Clock;
    logic                   Resetn;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   cdb_hold;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic                   proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_hold  (cdb_hold),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .proto_err (proto_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_unit(input int i, input logic v, input logic [TAG_W-1:0] t,
                            input logic [DATA_W-1:0] d);
        req_valid[i]                = v;
        req_tag[i*TAG_W +: TAG_W]   = t;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic reset_pulse();
        Resetn    = 1'b0;
        req_valid = '0;
        cdb_hold  = 1'b0;
        #1;
        Resetn = 1'b1;
        #1;
    endtask

    task automatic check_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                             input logic [DATA_W-1:0] d);
        check({name, "_valid"}, 32'(cdb_valid), 32'(v));
        check({name, "_tag"},   32'(cdb_tag),   32'(t));
        check({name, "_data"},  32'(cdb_data),  32'(d));
    endtask

    initial begin
        Resetn    = 1'b0;
        cdb_hold  = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;

        // Reset state; grants forced low while in reset even with requests present.
        set_unit(0, 1'b1, 3'd1, 16'h0011);
        set_unit(1, 1'b1, 3'd4, 16'h0044);
        set_unit(2, 1'b1, 3'd6, 16'h0066);
        #2;
        check("rst_ready", 32'(req_ready), 32'h0);
        check_cdb("rst_cdb", 1'b0, 3'd0, 16'h0000);
        check("rst_err", 32'(proto_err), 32'h0);
        req_valid = '0;
        step();
        step();
        Resetn = 1'b1;

        // Single request from unit 1.
        step();
        set_unit(1, 1'b1, 3'd5, 16'h00A3);
        #1;
        check("single_ready", 32'(req_ready), 32'b010);
        step();
        check_cdb("single_bcast", 1'b1, 3'd5, 16'h00A3);
        set_unit(1, 1'b0, 3'd5, 16'h00A3);

        // rr_ptr is now 2: units 1 and 2 valid -> unit 2 picked.
        set_unit(1, 1'b1, 3'd3, 16'h0333);
        set_unit(2, 1'b1, 3'd7, 16'h0777);
        #1;
        check("ptr2_ready", 32'(req_ready), 32'b100);

        // Asynchronous reset mid-stream.
        Resetn = 1'b0;
        #1;
        check_cdb("async_rst", 1'b0, 3'd0, 16'h0000);
        check("async_rst_ready", 32'(req_ready), 32'h0);
        Resetn = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b010);
        step();
        check_cdb("post_rst_b1", 1'b1, 3'd3, 16'h0333);
        set_unit(1, 1'b0, 3'd3, 16'h0333);
        #1;
        check("post_rst_ready2", 32'(req_ready), 32'b100);
        step();
        check_cdb("post_rst_b2", 1'b1, 3'd7, 16'h0777);
        req_valid = '0;
        step();
        check_cdb("idle_hold_vals", 1'b0, 3'd7, 16'h0777);
        check("idle_err", 32'(proto_err), 32'h0);

        // All units continuously valid from reset: grant 0,1,2,0,1.
        reset_pulse();
        set_unit(0, 1'b1, 3'd1, 16'h0011);
        set_unit(1, 1'b1, 3'd4, 16'h0044);
        set_unit(2, 1'b1, 3'd6, 16'h0066);
        #1;
        check("rr_g0", 32'(req_ready), 32'b001);
        step();
        check_cdb("rr_b0", 1'b1, 3'd1, 16'h0011);
        check("rr_g1", 32'(req_ready), 32'b010);
        step();
        check_cdb("rr_b1", 1'b1, 3'd4, 16'h0044);
        check("rr_g2", 32'(req_ready), 32'b100);
        step();
        check_cdb("rr_b2", 1'b1, 3'd6, 16'h0066);
        check("rr_g3", 32'(req_ready), 32'b001);
        step();
        check_cdb("rr_b3", 1'b1, 3'd1, 16'h0011);
        check("rr_g4", 32'(req_ready), 32'b010);
        check("rr_err", 32'(proto_err), 32'h0);

        // Hold blocks grants for three cycles with units 0 and 2 waiting.
        reset_pulse();
        cdb_hold = 1'b1;
        set_unit(0, 1'b1, 3'd2, 16'h0202);
        set_unit(2, 1'b1, 3'd6, 16'h0606);
        #1;
        check("hold_ready0", 32'(req_ready), 32'b000);
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_ready", 32'(req_ready), 32'b000);
            check("hold_cdbv", 32'(cdb_valid), 32'h0);
        end
        cdb_hold = 1'b0;
        #1;
        check("rel_ready0", 32'(req_ready), 32'b001);
        step();
        check_cdb("rel_b0", 1'b1, 3'd2, 16'h0202);
        set_unit(0, 1'b0, 3'd2, 16'h0202);
        cdb_hold = 1'b1;
        #1;
        check("hold_during_bcast", 32'(req_ready), 32'b000);
        step();
        check_cdb("hold_bcast_ends", 1'b0, 3'd2, 16'h0202);
        cdb_hold = 1'b0;
        #1;
        check("rel_ready2", 32'(req_ready), 32'b100);
        step();
        check_cdb("rel_b2", 1'b1, 3'd6, 16'h0606);
        req_valid = '0;
        step();
        check("hold_err", 32'(proto_err), 32'h0);

        // Unit 2 changes data while waiting.
        reset_pulse();
        set_unit(0, 1'b1, 3'd1, 16'h0101);
        set_unit(2, 1'b1, 3'd7, 16'h0777);
        step();
        check_cdb("dchg_b0", 1'b1, 3'd1, 16'h0101);
        check("dchg_err0", 32'(proto_err), 32'h0);
        set_unit(0, 1'b0, 3'd1, 16'h0101);
        set_unit(2, 1'b1, 3'd7, 16'h0778);
        step();
        check_cdb("dchg_b2", 1'b1, 3'd7, 16'h0778);
        check("dchg_err", 32'(proto_err), 32'h1);
        req_valid = '0;
        step();
        step();
        check("dchg_sticky", 32'(proto_err), 32'h1);
        Resetn = 1'b0;
        #1;
        check("err_cleared", 32'(proto_err), 32'h0);
        Resetn = 1'b1;

        // Unit 2 drops valid without a grant.
        step();
        set_unit(0, 1'b1, 3'd1, 16'h0101);
        set_unit(2, 1'b1, 3'd7, 16'h0777);
        step();
        req_valid = '0;
        #1;
        check("drop_err_pre", 32'(proto_err), 32'h0);
        step();
        check("drop_err", 32'(proto_err), 32'h1);
        check("drop_cdbv", 32'(cdb_valid), 32'h0);

        // Tag 0 request is broadcast but flagged.
        reset_pulse();
        set_unit(1, 1'b1, 3'd0, 16'h1234);
        #1;
        check("tag0_ready", 32'(req_ready), 32'b010);
        step();
        check_cdb("tag0_bcast", 1'b1, 3'd0, 16'h1234);
        check("tag0_err", 32'(proto_err), 32'h1);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) among the functional units: adder, multiplier and load unit.
- Each unit raises a completed result, tagged with its reservation-station ID, and holds it until granted.
- The arbiter grants one unit per cycle, round-robin, and drives the registered broadcast.
- Reservation stations and the register file snoop the broadcast to resolve Qj/Qk and write back.

Parameters:
- NREQ, 3, number of requesting functional units.
- DATA_W, 16, result value width (matches the CDB value field).
- TAG_W, 3, reservation-station tag width; tag 0 is reserved for "no producer".

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-unit result pending.
- req_tag  in  NREQ*TAG_W  per-unit producing-station tag; unit i occupies bits [i*TAG_W +: TAG_W].
- req_data  in  NREQ*DATA_W  per-unit result value; unit i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot grant; the unit's result is consumed this cycle.
- cdb_hold  in  1  consumers cannot accept a broadcast this cycle.
- cdb_valid  out  1  broadcast present on the CDB.
- cdb_tag  out  TAG_W  broadcast producer tag.
- cdb_data  out  DATA_W  broadcast value.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, Clock. Resetn is asynchronous, active-low. All state is cleared immediately on Resetn low, independent of Clock.
- Reset values:
  - cdb_valid=0, cdb_tag=0, cdb_data=0, proto_err=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is combinational and is 0 while in reset.
- Grant (combinational):
  - If cdb_hold=1, req_ready is all zeros.
  - Otherwise, starting at index rr_ptr and wrapping modulo NREQ, the first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one bit of req_ready is set. req_ready never depends on req_tag or req_data.
- Transfer: occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge.
- Broadcast latency: exactly 1 cycle.
  - On the edge of a transfer from unit g: cdb_valid<=1, cdb_tag<=tag[g], cdb_data<=data[g], rr_ptr<=(g+1) mod NREQ.
  - On an edge with no transfer: cdb_valid<=0, and cdb_tag/cdb_data hold their last values. rr_ptr is unchanged.
- Throughput: one broadcast per cycle with back-to-back grants. cdb_valid may stay high for consecutive cycles, carrying different tags.
- Fairness: a continuously valid requester is granted within NREQ non-hold cycles.
- Requester rules:
  - Once req_valid[i] rises, tag and data must stay stable and valid must stay high until the transfer.
  - Violation sets proto_err: req_valid[i] falling without a grant, or tag/data changing while valid and not granted. The arbiter keeps a one-cycle registered copy of valid, tag and data per requester for this check.
- Tag 0: a request with req_valid=1 and req_tag=0 is still granted and broadcast normally, and it sets proto_err.
- proto_err is sticky until reset.
- cdb_hold asserted while cdb_valid=1: the current broadcast still lasts exactly one cycle (hold only blocks new grants).
- Simultaneous requests from all units: pointer order applies. Example with rr_ptr=1: grant order is 1, 2, 0.
- Reset mid-operation: any pending grant is dropped. Requesters must re-present after Resetn rises. The first grant after reset goes to the lowest valid index.

Decomposition:
- Shared package tomasulo_pkg:
  - Constants DATA_W, TAG_W, TAG_NONE=0, and the station-tag assignments (adder stations, multiplier stations, load buffers).
  - A CDB bundle type (valid, tag, data), reused by reservation stations and the register status table.
- One sub-module: rr_pick. It takes the request vector and pointer and returns the one-hot grant plus the encoded index. It is purely combinational and reusable for issue arbitration.

Test Plan:
- Single request: reset, then req_valid[1]=1, tag=5, data=16'h00A3 -> req_ready[1]=1 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=16'h00A3; following cycle cdb_valid=0.
- All units continuously valid, tags 1/4/6, starting from reset -> grants in cycle order 0, 1, 2, 0, 1, 2; cdb_tag sequence 1, 4, 6, 1 with cdb_valid held high.
- cdb_hold=1 for 3 cycles with units 0 and 2 valid -> req_ready=0 and cdb_valid=0 throughout; after release, unit 0 is granted, then unit 2.
- Unit 2 drops req_valid without a grant, or changes data while waiting -> proto_err=1 the next cycle and stays 1 until Resetn low.
- Request with tag 0 -> broadcast occurs with cdb_tag=0 and proto_err=1.
- Resetn pulsed low mid-stream with rr_ptr=2 -> outputs go to 0 immediately (asynchronously); after release with units 1 and 2 valid, unit 1 is granted first.
